// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared types and constants for the iterative shift controller.
//   - op_i encodings (OP_*) as they arrive from the decoder
//   - shift_op_e : internal shift operation after decoding
//   - shift_state_e : controller FSM states
//   - decode_op() : maps the raw two-bit op onto shift_op_e (2'b11 -> SRL)
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

    localparam logic [1:0] OP_SLL     = 2'b00;
    localparam logic [1:0] OP_SRL     = 2'b01;
    localparam logic [1:0] OP_SRA     = 2'b10;
    localparam logic [1:0] OP_SRL_ALT = 2'b11;

    // Number of fixed-distance shifter families feeding the step mux
    localparam int NUM_SHIFTERS = 3;

    typedef enum logic [1:0] {
        SHIFT_SLL = OP_SLL,
        SHIFT_SRL = OP_SRL,
        SHIFT_SRA = OP_SRA
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

    // The unused encoding 2'b11 behaves as a logical right shift
    function automatic shift_op_e decode_op(input logic [1:0] op);
        shift_op_e result;
        case (op)
            OP_SLL:  result = SHIFT_SLL;
            OP_SRA:  result = SHIFT_SRA;
            default: result = SHIFT_SRL;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/configurable_mux.sv
// -----------------------------------------------------------------------------
// configurable_mux
// Generic one-hot AND-OR multiplexer.
// Ports:
//   i_sel  [NUM_INPUTS-1:0]        one-hot select (all-zero gives zero output)
//   i_data [NUM_INPUTS*WIDTH-1:0]  candidate inputs, input n at bits n*WIDTH
//   o_data [WIDTH-1:0]             selected value
// -----------------------------------------------------------------------------
module configurable_mux #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 2
) (
    input  logic [NUM_INPUTS-1:0]       i_sel,
    input  logic [NUM_INPUTS*WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]            o_data
);

    // AND-OR reduction; a one-hot select keeps this a flat gate tree with no
    // priority chain between the candidates.
    always_comb begin
        o_data = '0;
        for (int n = 0; n < NUM_INPUTS; n++) begin
            if (i_sel[n]) begin
                o_data = o_data | i_data[n*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/shift_step_unit.sv
// -----------------------------------------------------------------------------
// shift_step_unit
// Combinational single step of the iterative shifter: applies a shift by the
// fixed distance 2^i_step in the direction/fill chosen by i_op.
// Ports:
//   i_data [nb_bits_data-1:0]  current working value
//   i_op                       decoded shift operation (shift_op_e)
//   i_step [STEP_W-1:0]        step index k, distance is 2^k
//   o_data [nb_bits_data-1:0]  shifted value
// -----------------------------------------------------------------------------
module shift_step_unit
    import shift_ctrl_pkg::*;
#(
    parameter int nb_bits_data  = 32,
    parameter int nb_bits_shamt = 5,
    parameter int STEP_W        = (nb_bits_shamt > 1) ? $clog2(nb_bits_shamt) : 1
) (
    input  logic [nb_bits_data-1:0] i_data,
    input  shift_op_e               i_op,
    input  logic [STEP_W-1:0]       i_step,
    output logic [nb_bits_data-1:0] o_data
);

    localparam int NUM_CANDS = NUM_SHIFTERS * nb_bits_shamt;

    // Candidate layout: slot 0..NS-1 are left shifts, NS..2NS-1 logical right,
    // 2NS..3NS-1 arithmetic right, each ordered by step index.
    logic [NUM_CANDS*nb_bits_data-1:0] w_cands;
    logic [NUM_CANDS-1:0]              w_sel;

    // Every fixed-distance shifter is pure wiring; only the mux costs logic.
    for (genvar k = 0; k < nb_bits_shamt; k++) begin : g_dist
        localparam int DIST = 1 << k;
        assign w_cands[(k)*nb_bits_data +: nb_bits_data] =
            i_data << DIST;
        assign w_cands[(nb_bits_shamt + k)*nb_bits_data +: nb_bits_data] =
            i_data >> DIST;
        assign w_cands[(2*nb_bits_shamt + k)*nb_bits_data +: nb_bits_data] =
            {{DIST{i_data[nb_bits_data-1]}}, i_data[nb_bits_data-1:DIST]};
    end

    // Build the one-hot select from the operation family and the step index.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < nb_bits_shamt; k++) begin
            if (i_step == STEP_W'(k)) begin
                case (i_op)
                    SHIFT_SLL: w_sel[k]                   = 1'b1;
                    SHIFT_SRA: w_sel[2*nb_bits_shamt + k] = 1'b1;
                    default:   w_sel[nb_bits_shamt + k]   = 1'b1;
                endcase
            end
        end
    end

    configurable_mux #(
        .WIDTH      (nb_bits_data),
        .NUM_INPUTS (NUM_CANDS)
    ) u_mux (
        .i_sel  (w_sel),
        .i_data (w_cands),
        .o_data (o_data)
    );

endmodule

// File: rtl/iterative_shift_controller.sv
// -----------------------------------------------------------------------------
// iterative_shift_controller
// Multi-cycle SLL/SRL/SRA engine: one shift-amount bit is consumed per cycle,
// MSB first, using shift_step_unit as the only shift datapath.
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   start_i            request, accepted in IDLE or DONE only
//   op_i [1:0]         00 SLL, 01 SRL, 10 SRA, 11 SRL
//   data_i, shamt_i    operand and shift amount, captured on accept
//   busy_o             high while stepping
//   done_o             one-cycle pulse, data_o valid in that cycle
//   data_o             registered result, held until the next result
// Optional macro SHIFT_EARLY_EXIT_EN: finish as soon as no set shamt bits
// remain below the current step (shamt 0 completes straight from accept).
// Without it the latency is fixed at nb_bits_shamt+1 cycles.
// -----------------------------------------------------------------------------
module iterative_shift_controller
    import shift_ctrl_pkg::*;
#(
    parameter int nb_bits_data  = 32,
    parameter int nb_bits_shamt = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [1:0]               op_i,
    input  logic [nb_bits_data-1:0]  data_i,
    input  logic [nb_bits_shamt-1:0] shamt_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [nb_bits_data-1:0]  data_o
);

    localparam int                STEP_W = (nb_bits_shamt > 1) ? $clog2(nb_bits_shamt) : 1;
    localparam logic [STEP_W-1:0] K_LAST = STEP_W'(nb_bits_shamt - 1);

    shift_state_e             r_state;
    shift_state_e             w_state_next;
    shift_op_e                r_op;
    logic [nb_bits_data-1:0]  r_work;
    logic [nb_bits_data-1:0]  r_data_out;
    logic [nb_bits_shamt-1:0] r_shamt;
    logic [STEP_W-1:0]        r_k;

    logic                     w_accept;
    logic                     w_last_step;
    logic [nb_bits_data-1:0]  w_step_result;
    logic [nb_bits_data-1:0]  w_work_next;

    shift_step_unit #(
        .nb_bits_data  (nb_bits_data),
        .nb_bits_shamt (nb_bits_shamt),
        .STEP_W        (STEP_W)
    ) u_step (
        .i_data (r_work),
        .i_op   (r_op),
        .i_step (r_k),
        .o_data (w_step_result)
    );

    // The working value only moves when the current shamt bit is set.
    assign w_work_next = r_shamt[r_k] ? w_step_result : r_work;

`ifdef SHIFT_EARLY_EXIT_EN
    // Bits strictly below k; once they are all clear nothing is left to do.
    logic [nb_bits_shamt-1:0] w_low_mask;
    assign w_low_mask  = (nb_bits_shamt'(1) << r_k) - nb_bits_shamt'(1);
    assign w_last_step = ((r_shamt & w_low_mask) == '0);
`else
    assign w_last_step = (r_k == '0);
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs. A request is taken in IDLE or DONE;
    // start_i while stepping is simply not looked at.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                done_o = (r_state == ST_DONE);
                if (start_i) begin
                    w_accept = 1'b1;
`ifdef SHIFT_EARLY_EXIT_EN
                    w_state_next = (shamt_i == '0) ? ST_DONE : ST_SHIFT;
`else
                    w_state_next = ST_SHIFT;
`endif
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                busy_o = 1'b1;
                if (w_last_step) begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers. data_o is written only when a result completes, so
    // it stays stable across a back-to-back accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op       <= SHIFT_SLL;
            r_work     <= '0;
            r_data_out <= '0;
            r_shamt    <= '0;
            r_k        <= '0;
        end else if (w_accept) begin
            r_op    <= decode_op(op_i);
            r_work  <= data_i;
            r_shamt <= shamt_i;
            r_k     <= K_LAST;
`ifdef SHIFT_EARLY_EXIT_EN
            if (shamt_i == '0) begin
                r_data_out <= data_i;
            end
`endif
        end else if (r_state == ST_SHIFT) begin
            r_work <= w_work_next;
            if (r_k != '0) begin
                r_k <= r_k - STEP_W'(1);
            end
            if (w_last_step) begin
                r_data_out <= w_work_next;
            end
        end
    end

    assign data_o = r_data_out;

endmodule
